// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - FSM states, frame field encodings and read decode for the MDIO master
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_RX,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_C22    = 2'b01;
  localparam logic [1:0] ST_C45    = 2'b00;
  localparam logic [1:0] OP_C22_RD = 2'b10;
  localparam int         FRAME_W   = 32;
  localparam int         RX_BITS   = 18;

  // Clause 45 read and post-read-increment both have OP[1] set
  function automatic logic is_read(input logic [1:0] st, input logic [1:0] op);
    return ((st == ST_C22) && (op == OP_C22_RD)) || ((st == ST_C45) && op[1]);
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// rtl/mdio_clkgen.sv - MDC divider with single-clk rise/fall strobes; held low while disabled
module mdio_clkgen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          wrap;

  assign wrap = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign mdc      = mdc_q;
  assign mdc_rise = wrap && !mdc_q;
  assign mdc_fall = wrap && mdc_q;

endmodule

// File: rtl/mdio_master_param.sv
// rtl/mdio_master_param.sv - MDIO master FSM; MDIO_TA_CHECK_EN enables turnaround response check
module mdio_master_param
  import mdio_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out,
  output logic        busy,
  output logic        rd_err
);

  localparam logic [5:0] PRE_LAST   = 6'(PRE_LEN - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_W - 1);
  localparam logic [5:0] RD_HANDOFF = 6'(RX_BITS);
  localparam logic [5:0] RX_LAST    = 6'(RX_BITS - 1);

  state_t              state_q;
  logic [5:0]          cnt_q;
  logic [FRAME_W-1:0]  tx_q;
  logic [15:0]         rx_q;
  logic [15:0]         rd_data_q;
  logic                rd_q, rdy_q, oe_q, out_q, busy_q;
  logic                mdc_en, mdc_rise, mdc_fall;

  assign mdc_en = (state_q == S_PRE) || (state_q == S_FRAME) || (state_q == S_RX);

  mdio_clkgen #(.DIV(DIV)) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .en       (mdc_en),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  // cnt_q holds the remaining preamble bits, then the index of the frame/RX bit on the wire
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rd_q      <= 1'b0;
      rdy_q     <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mdio_start) begin
            tx_q   <= t_data;
            rd_q   <= is_read(t_data[31:30], t_data[29:28]);
            busy_q <= 1'b1;
            oe_q   <= 1'b1;
            if (PRE_LEN == 0) begin
              state_q <= S_FRAME;
              cnt_q   <= FRAME_LAST;
              out_q   <= t_data[FRAME_W-1];
            end else begin
              state_q <= S_PRE;
              cnt_q   <= PRE_LAST;
              out_q   <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (mdc_fall) begin
            if (cnt_q == '0) begin
              state_q <= S_FRAME;
              cnt_q   <= FRAME_LAST;
              out_q   <= tx_q[FRAME_W-1];
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        S_FRAME: begin
          if (mdc_fall) begin
            if (rd_q && (cnt_q == RD_HANDOFF)) begin
              state_q <= S_RX;
              cnt_q   <= RX_LAST;
              oe_q    <= 1'b0;
              out_q   <= 1'b0;
            end else if (cnt_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              oe_q    <= 1'b0;
              out_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 6'd1;
              out_q <= tx_q[FRAME_W-2];
              tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
        S_RX: begin
          // After all 18 shifts the turnaround bits have fallen out of the top
          if (mdc_rise) rx_q <= {rx_q[14:0], mdio_in};
          if (mdc_fall) begin
            if (cnt_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        S_DONE: begin
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
          if (rd_q) rd_data_q <= rx_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MDIO_TA_CHECK_EN
  localparam logic [5:0] TA_IDX = RX_LAST - 6'd1;

  logic ta_bad_q, rd_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ta_bad_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && mdio_start) rd_err_q <= 1'b0;
      if ((state_q == S_RX) && mdc_rise && (cnt_q == TA_IDX)) ta_bad_q <= mdio_in;
      if ((state_q == S_RX) && mdc_fall && (cnt_q == '0)) rd_err_q <= ta_bad_q;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  assign rd_data  = rd_data_q;
  assign data_rdy = rdy_q;
  assign mdio_oe  = oe_q;
  assign mdio_out = out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mdio_master_param.sv
// tb/tb_mdio_master_param.sv - randomized bench for mdio_master_param against a bit-sequence model
module tb_mdio_master_param;

  localparam int DIV0 = 2;
  localparam int PRE0 = 32;
  localparam int DIV1 = 1;
  localparam int PRE1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1, start0, start1, mdio_in;
  logic [31:0] t_data;
  logic [15:0] rd_data0, rd_data1;
  logic        data_rdy0, mdc0, oe0, out0, busy0, rd_err0;
  logic        data_rdy1, mdc1, oe1, out1, busy1, rd_err1;

  mdio_master_param #(.DIV(DIV0), .PRE_LEN(PRE0)) u_dut0 (
    .clk(clk), .reset(reset0), .mdio_start(start0), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_data0), .data_rdy(data_rdy0), .mdc(mdc0), .mdio_oe(oe0),
    .mdio_out(out0), .busy(busy0), .rd_err(rd_err0)
  );

  mdio_master_param #(.DIV(DIV1), .PRE_LEN(PRE1)) u_dut1 (
    .clk(clk), .reset(reset1), .mdio_start(start1), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_data1), .data_rdy(data_rdy1), .mdc(mdc1), .mdio_oe(oe1),
    .mdio_out(out1), .busy(busy1), .rd_err(rd_err1)
  );

  logic        sel;
  logic [15:0] m_rd_data;
  logic        m_rdy, m_mdc, m_oe, m_out, m_busy, m_err;
  assign m_rd_data = sel ? rd_data1  : rd_data0;
  assign m_rdy     = sel ? data_rdy1 : data_rdy0;
  assign m_mdc     = sel ? mdc1      : mdc0;
  assign m_oe      = sel ? oe1       : oe0;
  assign m_out     = sel ? out1      : out0;
  assign m_busy    = sel ? busy1     : busy0;
  assign m_err     = sel ? rd_err1   : rd_err0;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_rd [2];
  logic        model_err [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic s, input logic [31:0] frame, input logic [15:0] phy,
                         input logic ta1, input logic poke);
    int div, pre, nbits, drive_n, rises, busy_cnt, first_busy, rdy_idx, rdy_cnt, viol, mism, idx;
    logic exp_read, prev_mdc, prev_out, eo, ev;
    logic [17:0] rxbits;
    logic rec_out[$];
    logic rec_oe[$];
    div = s ? DIV1 : DIV0;
    pre = s ? PRE1 : PRE0;
    sel = s;
    exp_read = ((frame[31:30] == 2'b01) && (frame[29:28] == 2'b10)) ||
               ((frame[31:30] == 2'b00) && frame[29]);
    nbits   = pre + 32;
    drive_n = exp_read ? pre + 14 : nbits;
    rxbits  = {1'($urandom), ta1, phy};
    @(negedge clk);
    t_data = frame;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    if (s) start1 = 1'b0; else start0 = 1'b0;
    rises = 0; busy_cnt = 0; first_busy = -1; rdy_idx = -1; rdy_cnt = 0; viol = 0;
    prev_mdc = 1'b0; prev_out = 1'b0;
    for (int c = 1; c <= nbits * 2 * div + 8; c++) begin
      if (c > 1) @(negedge clk);
      if (m_busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (m_rdy) begin
        rdy_cnt++;
        if (rdy_idx < 0) rdy_idx = c;
      end
      if (c > 1 && m_out !== prev_out && !(prev_mdc && !m_mdc)) viol++;
      if (m_mdc && !prev_mdc) begin
        rec_out.push_back(m_out);
        rec_oe.push_back(m_oe);
        rises++;
      end
      if (!m_mdc) begin
        idx = rises - (pre + 14);
        mdio_in = (exp_read && idx >= 0 && idx < 18) ? rxbits[17 - idx] : 1'($urandom);
      end
      if (poke && c == 7) begin
        t_data = $urandom;
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (poke && c == 8) begin
        if (s) start1 = 1'b0; else start0 = 1'b0;
      end
      prev_mdc = m_mdc;
      prev_out = m_out;
    end
    mism = 0;
    for (int k = 0; k < nbits; k++) begin
      eo = (k < drive_n);
      ev = !eo ? 1'b0 : (k < pre) ? 1'b1 : frame[31 - (k - pre)];
      if (k >= rec_out.size()) mism++;
      else if (rec_out[k] !== ev || rec_oe[k] !== eo) mism++;
    end
    if (exp_read) model_rd[s] = phy;
`ifdef MDIO_TA_CHECK_EN
    model_err[s] = exp_read & ta1;
`else
    model_err[s] = 1'b0;
`endif
    chk("mdc_rises", rises, nbits);
    chk("bit_seq_errors", mism, 0);
    chk("busy_first_clk", first_busy, 1);
    chk("busy_len", busy_cnt, nbits * 2 * div);
    chk("rdy_clk", rdy_idx, nbits * 2 * div + 2);
    chk("rdy_pulses", rdy_cnt, 1);
    chk("drive_edge_viol", viol, 0);
    chk("rd_data", m_rd_data, model_rd[s]);
    chk("rd_err", m_err, model_err[s]);
    chk("idle_mdc", m_mdc, 0);
    chk("idle_oe", m_oe, 0);
    chk("idle_busy", m_busy, 0);
  endtask

  initial begin
    int toggles, nz, r, rdy_seen;
    logic prev;
    logic [31:0] f;
    model_rd[0] = '0; model_rd[1] = '0;
    model_err[0] = 1'b0; model_err[1] = 1'b0;
    sel = 1'b0; reset0 = 1'b0; reset1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mdio_in = 1'b0; t_data = '0;

    repeat (3) begin
      @(negedge clk);
      start0 = 1'($urandom); start1 = 1'($urandom); t_data = $urandom; mdio_in = 1'($urandom);
    end
    chk("reset_outs0", {rd_data0, data_rdy0, mdc0, oe0, out0, busy0, rd_err0}, 0);
    chk("reset_outs1", {rd_data1, data_rdy1, mdc1, oe1, out1, busy1, rd_err1}, 0);
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    reset0 = 1'b1; reset1 = 1'b1;
    toggles = 0; nz = 0; prev = mdc0;
    repeat (10) begin
      @(negedge clk);
      if (mdc0 !== prev) toggles++;
      prev = mdc0;
      if ({rd_data0, data_rdy0, mdc0, oe0, out0, busy0, rd_err0, rd_data1, data_rdy1,
           mdc1, oe1, out1, busy1, rd_err1} !== '0) nz++;
    end
    chk("post_reset_mdc_toggles", toggles, 0);
    chk("post_reset_nonzero", nz, 0);

    run_txn(1'b0, 32'h508AA5A5, 16'h0000, 1'b0, 1'b0);
    run_txn(1'b0, 32'h60880000, 16'h1234, 1'b0, 1'b0);
    run_txn(1'b0, 32'h30880000, 16'hBEEF, 1'b0, 1'b0);
    run_txn(1'b0, 32'h10881234, 16'h5555, 1'b0, 1'b0);
    run_txn(1'b0, 32'h60880000, 16'hFFFF, 1'b1, 1'b0);
    run_txn(1'b0, 32'h20C40000, 16'h0F0F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      f = $urandom;
      run_txn(1'b0, f, 16'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    run_txn(1'b1, 32'h508AA5A5, 16'h0000, 1'b0, 1'b1);
    run_txn(1'b1, 32'h60880000, 16'hA5C3, 1'b0, 1'b1);
    run_txn(1'b1, 32'h70880000, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      f = $urandom;
      run_txn(1'b1, f, 16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    sel = 1'b1;
    @(negedge clk);
    t_data = 32'h60880000;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    r = 0; prev = mdc1;
    for (int c = 0; c < 200 && r < 10; c++) begin
      @(negedge clk);
      if (mdc1 && !prev) r++;
      prev = mdc1;
    end
    chk("reached_bit10", r, 10);
    #1 reset1 = 1'b0;
    #1 chk("async_reset_outs", {rd_data1, data_rdy1, mdc1, oe1, out1, busy1, rd_err1}, 0);
    repeat (2) @(negedge clk);
    reset1 = 1'b1;
    rdy_seen = 0; toggles = 0; prev = mdc1;
    repeat (80) begin
      @(negedge clk);
      if (data_rdy1) rdy_seen++;
      if (mdc1 !== prev) toggles++;
      prev = mdc1;
    end
    chk("abandoned_rdy", rdy_seen, 0);
    chk("abandoned_mdc_toggles", toggles, 0);
    chk("abandoned_busy", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
